imem_dmem_arbiter: RTL and testbench

Shares one single-port, word-wide synchronous SRAM between the instruction-fetch stage and the load/store unit of the 5-stage RV32I pipeline. Each cycle it grants at most one requester, drives the SRAM port, and routes the next-cycle read data back to the granted requester. The LSU normally has priority, and a bounded-streak rule prevents fetch starvation. A requester that is not granted must hold its stage; the pipeline's hazard logic uses the grant signals as stall inputs.

---
 rtl/arb_pkg.sv | 14 +
 rtl/imem_dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default constants for the instruction/data SRAM arbiter.
package arb_pkg;

    localparam int unsigned ARB_ADDR_W        = 11;
    localparam int unsigned ARB_MAX_LS_STREAK = 4;

    // Which requester owns the response arriving next cycle
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_e;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the load/store unit.
// LSU wins conflicts until it has been granted MAX_LS_STREAK times in a row
// while fetch waited; then fetch gets one grant and the streak restarts.
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = ARB_ADDR_W,
    parameter int unsigned MAX_LS_STREAK = ARB_MAX_LS_STREAK
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,

    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [31:0]       ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                ls_load_q, ls_load_d;

    // Byte-offset and out-of-range address bits are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                ls_addr_i[31:ADDR_W+2], ls_addr_i[1:0]};

    // Grant decision, streak update, SRAM port mux and response demux
    always_comb begin
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = 32'h0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = 32'h0;
        owner_d     = OWN_NONE;
        streak_d    = '0;
        ls_load_d   = 1'b0;

        if (rst_ni) begin
            if (if_req_i && ls_req_i) begin
                if (streak_q == STREAK_MAX) begin
                    if_gnt_o = 1'b1;
                end else begin
                    ls_gnt_o = 1'b1;
                end
            end else begin
                if_gnt_o = if_req_i;
                ls_gnt_o = ls_req_i;
            end
        end

        // Streak only grows while fetch is actually being held off
        if (ls_gnt_o && if_req_i) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
        end

        if (if_gnt_o) begin
            mem_req_o  = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = if_addr_i[ADDR_W+1:2];
            owner_d    = OWN_IF;
        end else if (ls_gnt_o) begin
            mem_req_o   = 1'b1;
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_be_i;
            mem_addr_o  = ls_addr_i[ADDR_W+1:2];
            mem_wdata_o = ls_wdata_i;
            owner_d     = OWN_LS;
            ls_load_d   = ~ls_we_i;
        end

        // A response in flight when reset asserts is dropped
        if (rst_ni && owner_q == OWN_IF) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
        end
        if (rst_ni && owner_q == OWN_LS) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = ls_load_q ? mem_rdata_i : 32'h0;
        end
    end

    // Response owner, load flag and streak registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q   <= OWN_NONE;
            streak_q  <= '0;
            ls_load_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            ls_load_q <= ls_load_d;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a cycle-level reference model of the arbitration rules.
module tb_imem_dmem_arbiter;

    localparam int unsigned AW  = 11;
    localparam int unsigned MAX = 4;
    localparam int unsigned NW  = 1 << AW;

    logic          clk_i;
    logic          rst_ni;
    logic          if_req_i;
    logic [31:0]   if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [3:0]    ls_be_i;
    logic [31:0]   ls_addr_i;
    logic [31:0]   ls_wdata_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [31:0]   ls_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    imem_dmem_arbiter #(.ADDR_W(AW), .MAX_LS_STREAK(MAX)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_be_i     (ls_be_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Power-on contents shared by the SRAM model and the reference memory
    function automatic logic [31:0] init_word(input int unsigned i);
        return (32'(i) * 32'h0101_0103) ^ 32'hA5A5_0000;
    endfunction

    // Synchronous SRAM: read data valid the cycle after the request
    logic [31:0] sram    [NW];
    logic        written [NW];
    always @(posedge clk_i) begin
        if (mem_req_o && mem_we_o) begin
            logic [31:0] cur;
            cur = written[mem_addr_o] ? sram[mem_addr_o] : init_word(32'(mem_addr_o));
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
            sram[mem_addr_o]    <= cur;
            written[mem_addr_o] <= 1'b1;
            mem_rdata_i         <= $urandom;
        end else if (mem_req_o) begin
            mem_rdata_i <= written[mem_addr_o] ? sram[mem_addr_o] : init_word(32'(mem_addr_o));
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    int unsigned total;
    int unsigned passed;
    int unsigned fails;

    // Reference model state
    logic [31:0] ref_mem [NW];
    int unsigned ls_run;
    logic        pend_if_v, pend_ls_v;
    logic [31:0] pend_if_d, pend_ls_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check every output against the model, advance model
    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic lr, input logic we, input logic [3:0] be,
                        input logic [31:0] la, input logic [31:0] wd,
                        output logic gi, output logic gl);
        int unsigned iw, lw;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        @(negedge clk_i);
        rst_ni     = rst;
        if_req_i   = ir;
        if_addr_i  = ia;
        ls_req_i   = lr;
        ls_we_i    = we;
        ls_be_i    = be;
        ls_addr_i  = la;
        ls_wdata_i = wd;
        #1;
        iw = int'(ia[AW+1:2]);
        lw = int'(la[AW+1:2]);
        gi = 1'b0;
        gl = 1'b0;
        if (rst) begin
            if (ir && lr) begin
                if (ls_run == MAX) gi = 1'b1;
                else               gl = 1'b1;
            end else begin
                gi = ir;
                gl = lr;
            end
        end
        ebe   = gi ? 4'hF : (gl ? be : 4'h0);
        eaddr = gi ? 32'(iw) : (gl ? 32'(lw) : 32'h0);

        chk("if_gnt",    32'(if_gnt_o),    32'(gi));
        chk("ls_gnt",    32'(ls_gnt_o),    32'(gl));
        chk("mem_req",   32'(mem_req_o),   32'(gi | gl));
        chk("mem_we",    32'(mem_we_o),    32'(gl & we));
        chk("mem_be",    32'(mem_be_o),    32'(ebe));
        chk("mem_addr",  32'(mem_addr_o),  eaddr);
        chk("mem_wdata", mem_wdata_o,      gl ? wd : 32'h0);
        chk("if_rvalid", 32'(if_rvalid_o), 32'(rst & pend_if_v));
        chk("if_rdata",  if_rdata_o,       (rst && pend_if_v) ? pend_if_d : 32'h0);
        chk("ls_rvalid", 32'(ls_rvalid_o), 32'(rst & pend_ls_v));
        chk("ls_rdata",  ls_rdata_o,       (rst && pend_ls_v) ? pend_ls_d : 32'h0);

        if (!rst) begin
            pend_if_v = 1'b0;
            pend_ls_v = 1'b0;
            pend_if_d = 32'h0;
            pend_ls_d = 32'h0;
            ls_run    = 0;
        end else begin
            pend_if_v = gi;
            pend_if_d = gi ? ref_mem[iw] : 32'h0;
            pend_ls_v = gl;
            pend_ls_d = (gl && !we) ? ref_mem[lw] : 32'h0;
            if (gl && we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[lw][8*b +: 8] = wd[8*b +: 8];
            ls_run = (gl && ir) ? ((ls_run + 1 > MAX) ? MAX : ls_run + 1) : 0;
        end
    endtask

    initial begin
        logic        gi, gl;
        logic [9:0]  pat;
        logic        pi, pl, pwe;
        logic [31:0] pia, pla, pwd;
        logic [3:0]  pbe;
        logic        rst;

        total = 0; passed = 0; fails = 0;
        ls_run = 0;
        pend_if_v = 1'b0; pend_ls_v = 1'b0;
        pend_if_d = 32'h0; pend_ls_d = 32'h0;
        for (int i = 0; i < int'(NW); i++) begin
            ref_mem[i] = init_word(32'(i));
            written[i] = 1'b0;
            sram[i]    = 32'h0;
        end
        rst_ni = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'h0;
        ls_addr_i = 32'h0; ls_wdata_i = 32'h0;

        // Reset with both requesting: nothing granted, outputs quiet
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, gi, gl);
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, gi, gl);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0, gi, gl);

        // Fetch stream 0x0, 0x4, 0x8
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gl);
        step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gl);
        chk("fetch_word0", if_rdata_o, init_word(0));
        step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gl);
        chk("fetch_addr2", 32'(mem_addr_o), 32'd2);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gl);
        chk("fetch_word2", if_rdata_o, init_word(2));

        // Store then load back the same word
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, gi, gl);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gl);
        chk("store_ack", ls_rdata_o, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gl);
        chk("load_back", ls_rdata_o, 32'hDEAD_BEEF);

        // Continuous contention: LS x4 then IF, repeating
        pat = 10'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0, gi, gl);
            pat[9-c] = gl;
        end
        chk("streak_pattern", 32'(pat), 32'(10'b11110_11110));

        // Fetch wins the first cycle the LSU drops its request
        step(1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 4'hF, 32'h108, 32'h0, gi, gl);
        step(1'b1, 1'b1, 32'h24, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, gi, gl);
        chk("if_after_ls_drop", 32'(if_gnt_o), 32'd1);

        // Load granted (streak 1), then reset: response dropped, streak cleared
        step(1'b1, 1'b1, 32'h28, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gl);
        step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0, gi, gl);
        chk("dropped_rvalid", 32'(ls_rvalid_o), 32'd0);
        step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0, gi, gl);
        pat = 10'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 32'h28, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, gi, gl);
            pat[4-c] = gi;
        end
        chk("streak_after_reset", 32'(pat), 32'(10'b00000_00001));

        // Byte store at 0x202 while fetch also requests
        step(1'b1, 1'b1, 32'h2C, 1'b1, 1'b1, 4'b0100, 32'h202, 32'h00AB_0000, gi, gl);
        chk("byte_addr", 32'(mem_addr_o), 32'h80);
        chk("byte_if_blocked", 32'(if_gnt_o), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, gi, gl);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, gi, gl);
        chk("byte_merge", ls_rdata_o, {init_word(32'h80)[31:24], 8'hAB, init_word(32'h80)[15:0]});

        // Random traffic; requests stay stable until the model grants them
        pi = 1'b0; pl = 1'b0; pwe = 1'b0;
        pia = 32'h0; pla = 32'h0; pwd = 32'h0; pbe = 4'h0;
        for (int c = 0; c < 400; c++) begin
            if (!pi && ($urandom_range(0, 9) < 6)) begin
                pi  = 1'b1;
                pia = $urandom;
                pia[AW+1:2] = AW'($urandom_range(0, 63));
            end
            if (!pl && ($urandom_range(0, 9) < 6)) begin
                pl  = 1'b1;
                pwe = 1'($urandom_range(0, 1));
                pbe = 4'($urandom);
                pwd = $urandom;
                pla = $urandom;
                pla[AW+1:2] = AW'($urandom_range(0, 63));
            end
            rst = ($urandom_range(0, 49) != 0);
            step(rst, pi, pia, pl, pwe, pbe, pla, pwd, gi, gl);
            if (!rst) begin
                pi = 1'b0;
                pl = 1'b0;
            end else begin
                if (gi) pi = 1'b0;
                if (gl) pl = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
